regfile_wb_sched: RTL and testbench

Write-port scheduler and scoreboard for the 32×32 general-purpose register file of the static pipeline CPU. It shares the single register-file write port between two sources:
- the in-order pipeline writeback, which has fixed priority;
- the multi-cycle long-latency unit (mul/div), whose results are buffered in a small holding queue.

It also tracks registers with pending long-latency results and stalls decode on RAW/WAW hazards against them.

---
 rtl/regfile_wb_sched_pkg.sv | 16 +
 rtl/regfile_wb_sched_if.sv | 42 ++++
 rtl/regfile_wb_fifo.sv | 45 ++++
 rtl/regfile_wb_sched.sv | 110 +++++++++++
 tb/tb_regfile_wb_sched.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_sched_pkg.sv
`default_nettype none
// ============================================================================
// regfile_wb_sched_pkg : register-file widths and the write-port entry type
// Revision 1.0
// ============================================================================
package regfile_wb_sched_pkg;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 2**AW;

  typedef struct packed {
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } wb_entry_t;
endpackage
`default_nettype wire

// File: rtl/regfile_wb_sched_if.sv
`default_nettype none
// ============================================================================
// regfile_wb_sched_if : decode, writeback, long-unit and register-file signals
// Revision 1.0
// ============================================================================
interface regfile_wb_sched_if;
  import regfile_wb_sched_pkg::*;

  logic            id_valid;
  logic [AW-1:0]   id_rs;
  logic [AW-1:0]   id_rt;
  logic            id_use_rs;
  logic            id_use_rt;
  logic            id_wr_en;
  logic [AW-1:0]   id_waddr;
  logic            id_long;
  logic            id_stall;
  logic            wb_we;
  logic [AW-1:0]   wb_waddr;
  logic [DW-1:0]   wb_wdata;
  logic            lu_valid;
  logic [AW-1:0]   lu_waddr;
  logic [DW-1:0]   lu_wdata;
  logic            lu_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic [NREG-1:0] sb_busy;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_waddr, id_long,
    output wb_we, wb_waddr, wb_wdata, lu_valid, lu_waddr, lu_wdata,
    input  id_stall, lu_ready, rf_we, rf_waddr, rf_wdata, sb_busy
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_waddr, id_long,
    input  wb_we, wb_waddr, wb_wdata, lu_valid, lu_waddr, lu_wdata,
    output id_stall, lu_ready, rf_we, rf_waddr, rf_wdata, sb_busy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_fifo.sv
`default_nettype none
// ============================================================================
// regfile_wb_fifo : holding queue for long-unit results, head visible combinationally
// Revision 1.0
// ============================================================================
module regfile_wb_fifo
  import regfile_wb_sched_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  wire logic      clk,
  input  wire logic      rst,
  input  wire logic      i_push,
  input  wire wb_entry_t i_din,
  input  wire logic      i_pop,
  output wb_entry_t      o_head,
  output logic           o_full,
  output logic           o_empty
);
  localparam int PW = $clog2(QDEPTH);

  // One extra pointer bit separates full from empty.
  logic [PW:0] r_wptr;
  logic [PW:0] r_rptr;
  wb_entry_t   r_mem [QDEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + (PW+1)'(1);
      if (i_pop)  r_rptr <= r_rptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr[PW-1:0]] <= i_din;
  end

  assign o_head  = r_mem[r_rptr[PW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
endmodule
`default_nettype wire

// File: rtl/regfile_wb_sched.sv
`default_nettype none
// ============================================================================
// regfile_wb_sched : register-file write-port arbiter and long-latency scoreboard
// Option macro REGFILE_WB_SCHED_BYPASS_EN: empty-queue results write in the same cycle
// Revision 1.0
// ============================================================================
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  regfile_wb_sched_if.slave bus
);
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_byp;
  logic            w_starve;
  logic            w_set;
  wb_entry_t       w_head;
  wb_entry_t       w_din;
  logic [NREG-1:0] w_busy_nxt;
  logic [NREG-1:0] r_busy;
  logic [CW-1:0]   r_cnt;

`ifdef REGFILE_WB_SCHED_BYPASS_EN
  assign w_byp = rst & w_empty & ~bus.wb_we & bus.lu_valid;
`else
  assign w_byp = 1'b0;
`endif

  assign bus.lu_ready = rst & ~w_full;
  assign w_push       = bus.lu_valid & bus.lu_ready & ~w_byp;
  assign w_pop        = rst & ~bus.wb_we & ~w_empty;
  assign w_din        = '{waddr: bus.lu_waddr, wdata: bus.lu_wdata};

  regfile_wb_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Writeback has fixed priority; the queue head only drains on idle WB cycles.
  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = bus.wb_waddr;
    bus.rf_wdata = bus.wb_wdata;
    if (!rst) begin
      bus.rf_we = 1'b0;
    end else if (bus.wb_we) begin
      bus.rf_we = 1'b1;
    end else if (!w_empty) begin
      bus.rf_we    = (w_head.waddr != '0);
      bus.rf_waddr = w_head.waddr;
      bus.rf_wdata = w_head.wdata;
    end else if (w_byp) begin
      bus.rf_we    = (bus.lu_waddr != '0);
      bus.rf_waddr = bus.lu_waddr;
      bus.rf_wdata = bus.lu_wdata;
    end
  end

  assign w_starve = (r_cnt >= CW'(STARVE_MAX));

  assign bus.id_stall = rst & bus.id_valid &
                        ((bus.id_use_rs & r_busy[bus.id_rs]) |
                         (bus.id_use_rt & r_busy[bus.id_rt]) |
                         (bus.id_wr_en  & r_busy[bus.id_waddr]) |
                         w_starve);

  assign w_set = bus.id_valid & ~bus.id_stall & bus.id_wr_en & bus.id_long &
                 (bus.id_waddr != '0);

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop) w_busy_nxt[w_head.waddr]   = 1'b0;
    if (w_byp) w_busy_nxt[bus.lu_waddr]   = 1'b0;
    if (w_set) w_busy_nxt[bus.id_waddr]   = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // The starve count saturates and holds until a pop so decode bubbles keep coming.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_pop || w_empty) begin
        r_cnt <= '0;
      end else if (bus.wb_we && !w_starve) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign bus.sb_busy = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_sched.sv
`default_nettype none
// ============================================================================
// tb_regfile_wb_sched : directed-vector bench for the write-port scheduler
// Revision 1.0
// ============================================================================
module tb_regfile_wb_sched;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  regfile_wb_sched_if bus();

  regfile_wb_sched #(.QDEPTH(2), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.id_valid = 1'b0; bus.id_rs = '0; bus.id_rt = '0;
    bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0; bus.id_wr_en = 1'b0;
    bus.id_waddr = '0; bus.id_long = 1'b0;
    bus.wb_we = 1'b0; bus.wb_waddr = '0; bus.wb_wdata = '0;
    bus.lu_valid = 1'b0; bus.lu_waddr = '0; bus.lu_wdata = '0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.id_valid = 1'($urandom); bus.id_rs = 5'($urandom); bus.id_rt = 5'($urandom);
      bus.id_use_rs = 1'b1; bus.id_use_rt = 1'b1; bus.id_wr_en = 1'($urandom);
      bus.id_waddr = 5'($urandom); bus.id_long = 1'($urandom);
      bus.wb_we = 1'b1; bus.wb_waddr = 5'($urandom); bus.wb_wdata = $urandom;
      bus.lu_valid = 1'b1; bus.lu_waddr = 5'($urandom); bus.lu_wdata = $urandom;
      #1;
      n_vec++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we got %b want 0", bus.rf_we); end
      n_vec++; if (bus.lu_ready !== 1'b0) begin n_err++; $display("FAIL reset_lu_ready got %b want 0", bus.lu_ready); end
      n_vec++; if (bus.id_stall !== 1'b0) begin n_err++; $display("FAIL reset_id_stall got %b want 0", bus.id_stall); end
      n_vec++; if (bus.sb_busy !== 32'h0) begin n_err++; $display("FAIL reset_sb_busy got %h want 0", bus.sb_busy); end
    end
    @(negedge clk); rst = 1'b1; idle(); #1;
    n_vec++; if (bus.lu_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_lu_ready got %b want 1", bus.lu_ready); end
    n_vec++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL post_reset_rf_we got %b want 0", bus.rf_we); end
  endtask

  task automatic test_long_raw();
    @(negedge clk); idle();
    bus.id_valid = 1'b1; bus.id_wr_en = 1'b1; bus.id_long = 1'b1; bus.id_waddr = 5'd5; #1;
    n_vec++; if (bus.id_stall !== 1'b0) begin n_err++; $display("FAIL raw_issue_stall got %b want 0", bus.id_stall); end
    @(negedge clk); idle();
    bus.id_valid = 1'b1; bus.id_use_rs = 1'b1; bus.id_rs = 5'd5; #1;
    n_vec++; if (bus.id_stall !== 1'b1) begin n_err++; $display("FAIL raw_read_stall got %b want 1", bus.id_stall); end
    n_vec++; if (bus.sb_busy !== 32'h0000_0020) begin n_err++; $display("FAIL raw_busy got %h want 00000020", bus.sb_busy); end
    @(negedge clk);
    bus.lu_valid = 1'b1; bus.lu_waddr = 5'd5; bus.lu_wdata = 32'h1234; #1;
    n_vec++; if (bus.lu_ready !== 1'b1) begin n_err++; $display("FAIL raw_lu_ready got %b want 1", bus.lu_ready); end
    n_vec++; if (bus.id_stall !== 1'b1) begin n_err++; $display("FAIL raw_accept_stall got %b want 1", bus.id_stall); end
`ifdef REGFILE_WB_SCHED_BYPASS_EN
    n_vec++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd5, 32'h1234}) begin n_err++;
      $display("FAIL raw_byp_write got %b/%0d/%h want 1/5/1234", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    @(negedge clk); bus.lu_valid = 1'b0; #1;
    n_vec++; if (bus.id_stall !== 1'b0) begin n_err++; $display("FAIL raw_release_stall got %b want 0", bus.id_stall); end
`else
    n_vec++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL raw_accept_rf_we got %b want 0", bus.rf_we); end
    @(negedge clk); bus.lu_valid = 1'b0; #1;
    n_vec++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd5, 32'h1234}) begin n_err++;
      $display("FAIL raw_write got %b/%0d/%h want 1/5/1234", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    n_vec++; if (bus.id_stall !== 1'b1) begin n_err++; $display("FAIL raw_clear_cycle_stall got %b want 1", bus.id_stall); end
    @(negedge clk); #1;
    n_vec++; if (bus.id_stall !== 1'b0) begin n_err++; $display("FAIL raw_release_stall got %b want 0", bus.id_stall); end
`endif
    n_vec++; if (bus.sb_busy !== 32'h0) begin n_err++; $display("FAIL raw_busy_clear got %h want 0", bus.sb_busy); end
  endtask

  task automatic test_port_conflict();
    @(negedge clk); idle();
    bus.wb_we = 1'b1; bus.wb_waddr = 5'd3; bus.wb_wdata = 32'hAAAA;
    bus.lu_valid = 1'b1; bus.lu_waddr = 5'd4; bus.lu_wdata = 32'hBBBB; #1;
    n_vec++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd3, 32'hAAAA}) begin n_err++;
      $display("FAIL conflict_wb got %b/%0d/%h want 1/3/aaaa", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    @(negedge clk); idle(); #1;
    n_vec++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd4, 32'hBBBB}) begin n_err++;
      $display("FAIL conflict_lu got %b/%0d/%h want 1/4/bbbb", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    @(negedge clk); #1;
    n_vec++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL conflict_drained got %b want 0", bus.rf_we); end
  endtask

  task automatic test_queue_full();
    logic [4:0]  la [1:6];
    logic [31:0] ld [1:6];
    la = '{5'd10, 5'd11, 5'd12, 5'd12, 5'd12, 5'd12};
    ld = '{32'h100, 32'h200, 32'h300, 32'h300, 32'h300, 32'h300};
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); idle();
      bus.wb_we = 1'b1; bus.wb_waddr = 5'd1; bus.wb_wdata = 32'h11; bus.id_valid = 1'b1;
      bus.lu_valid = 1'b1; bus.lu_waddr = la[c]; bus.lu_wdata = ld[c]; #1;
      n_vec++; if (bus.lu_ready !== (c <= 2)) begin n_err++;
        $display("FAIL full_ready_c%0d got %b want %b", c, bus.lu_ready, c <= 2); end
      n_vec++; if (bus.id_stall !== (c == 6)) begin n_err++;
        $display("FAIL full_starve_c%0d got %b want %b", c, bus.id_stall, c == 6); end
      n_vec++; if (bus.rf_waddr !== 5'd1) begin n_err++;
        $display("FAIL full_wb_wins_c%0d got %0d want 1", c, bus.rf_waddr); end
    end
    @(negedge clk); bus.wb_we = 1'b0; #1;
    n_vec++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd10, 32'h100}) begin n_err++;
      $display("FAIL full_pop1 got %b/%0d/%h want 1/10/100", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    n_vec++; if (bus.id_stall !== 1'b1) begin n_err++; $display("FAIL full_pop1_stall got %b want 1", bus.id_stall); end
    n_vec++; if (bus.lu_ready !== 1'b0) begin n_err++; $display("FAIL full_pop1_ready got %b want 0", bus.lu_ready); end
    @(negedge clk); #1;
    n_vec++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd11, 32'h200}) begin n_err++;
      $display("FAIL full_pop2 got %b/%0d/%h want 1/11/200", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    n_vec++; if (bus.lu_ready !== 1'b1) begin n_err++; $display("FAIL full_pop2_ready got %b want 1", bus.lu_ready); end
    n_vec++; if (bus.id_stall !== 1'b0) begin n_err++; $display("FAIL full_pop2_stall got %b want 0", bus.id_stall); end
    @(negedge clk); bus.lu_valid = 1'b0; #1;
    n_vec++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd12, 32'h300}) begin n_err++;
      $display("FAIL full_pop3 got %b/%0d/%h want 1/12/300", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    @(negedge clk); idle(); #1;
    n_vec++; if ({bus.rf_we, bus.lu_ready} !== 2'b01) begin n_err++;
      $display("FAIL full_drained got we=%b ready=%b want we=0 ready=1", bus.rf_we, bus.lu_ready); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk); idle();
    bus.id_valid = 1'b1; bus.id_wr_en = 1'b1; bus.id_long = 1'b1; bus.id_waddr = 5'd0; #1;
    n_vec++; if (bus.id_stall !== 1'b0) begin n_err++; $display("FAIL zero_issue_stall got %b want 0", bus.id_stall); end
    @(negedge clk); idle();
    bus.lu_valid = 1'b1; bus.lu_waddr = 5'd0; bus.lu_wdata = 32'hDEAD; #1;
    n_vec++; if (bus.sb_busy !== 32'h0) begin n_err++; $display("FAIL zero_busy got %h want 0", bus.sb_busy); end
    n_vec++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL zero_accept_rf_we got %b want 0", bus.rf_we); end
    @(negedge clk); bus.lu_waddr = 5'd6; bus.lu_wdata = 32'h66; #1;
    n_vec++; if (bus.lu_ready !== 1'b1) begin n_err++; $display("FAIL zero_ready got %b want 1", bus.lu_ready); end
`ifdef REGFILE_WB_SCHED_BYPASS_EN
    n_vec++; if ({bus.rf_we, bus.rf_waddr} !== {1'b1, 5'd6}) begin n_err++;
      $display("FAIL zero_next got %b/%0d want 1/6", bus.rf_we, bus.rf_waddr); end
    @(negedge clk); idle(); #1;
    n_vec++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL zero_done got %b want 0", bus.rf_we); end
`else
    n_vec++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL zero_pop_rf_we got %b want 0", bus.rf_we); end
    @(negedge clk); idle(); #1;
    n_vec++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd6, 32'h66}) begin n_err++;
      $display("FAIL zero_next got %b/%0d/%h want 1/6/66", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
`endif
  endtask

  task automatic test_latency();
    @(negedge clk); idle();
    bus.id_valid = 1'b1; bus.id_wr_en = 1'b1; bus.id_long = 1'b1; bus.id_waddr = 5'd7; #1;
    @(negedge clk); idle();
    bus.id_valid = 1'b1; bus.id_wr_en = 1'b1; bus.id_waddr = 5'd7;
    bus.lu_valid = 1'b1; bus.lu_waddr = 5'd7; bus.lu_wdata = 32'h55; #1;
    n_vec++; if (bus.id_stall !== 1'b1) begin n_err++; $display("FAIL lat_waw_stall got %b want 1", bus.id_stall); end
    n_vec++; if (bus.sb_busy !== 32'h0000_0080) begin n_err++; $display("FAIL lat_busy got %h want 00000080", bus.sb_busy); end
`ifdef REGFILE_WB_SCHED_BYPASS_EN
    n_vec++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd7, 32'h55}) begin n_err++;
      $display("FAIL lat_byp got %b/%0d/%h want 1/7/55", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    @(negedge clk); idle(); #1;
    n_vec++; if ({bus.rf_we, bus.sb_busy} !== {1'b0, 32'h0}) begin n_err++;
      $display("FAIL lat_after got we=%b busy=%h want we=0 busy=0", bus.rf_we, bus.sb_busy); end
`else
    n_vec++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL lat_t0 got %b want 0", bus.rf_we); end
    @(negedge clk); idle(); #1;
    n_vec++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd7, 32'h55}) begin n_err++;
      $display("FAIL lat_t1 got %b/%0d/%h want 1/7/55", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    n_vec++; if (bus.sb_busy !== 32'h0000_0080) begin n_err++; $display("FAIL lat_t1_busy got %h want 00000080", bus.sb_busy); end
    @(negedge clk); #1;
    n_vec++; if (bus.sb_busy !== 32'h0) begin n_err++; $display("FAIL lat_t2_busy got %h want 0", bus.sb_busy); end
`endif
  endtask

  task automatic test_reset_mid();
    @(negedge clk); idle();
    bus.id_valid = 1'b1; bus.id_wr_en = 1'b1; bus.id_long = 1'b1; bus.id_waddr = 5'd9; #1;
    @(negedge clk); idle();
    bus.wb_we = 1'b1; bus.wb_waddr = 5'd1; bus.wb_wdata = 32'h1;
    bus.lu_valid = 1'b1; bus.lu_waddr = 5'd9; bus.lu_wdata = 32'h99; #1;
    @(negedge clk); idle(); rst = 1'b0; #1;
    n_vec++; if ({bus.rf_we, bus.lu_ready} !== 2'b00) begin n_err++;
      $display("FAIL mid_reset got we=%b ready=%b want 0/0", bus.rf_we, bus.lu_ready); end
    @(negedge clk); rst = 1'b1; #1;
    n_vec++; if ({bus.rf_we, bus.lu_ready, bus.sb_busy} !== {1'b0, 1'b1, 32'h0}) begin n_err++;
      $display("FAIL mid_after got we=%b ready=%b busy=%h want 0/1/0", bus.rf_we, bus.lu_ready, bus.sb_busy); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    idle();
    test_reset();
    test_long_raw();
    test_port_conflict();
    test_queue_full();
    test_zero_reg();
    test_latency();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
